// File: rtl/uart_arb_pkg.sv
// ============================================================================
// Module   : uart_arb_pkg
// Purpose  : Shared types and constants for the UART transmit arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_LAUNCH     = 2'd1,
    ST_WAIT_START = 2'd2,
    ST_WAIT_DONE  = 2'd3
  } arb_state_e;

  localparam logic       REQ_CPU  = 1'b0;
  localparam logic       REQ_DBG  = 1'b1;
  localparam logic [7:0] ASCII_LF = 8'h0A;

endpackage

`default_nettype wire

// File: rtl/uart_arb_rr.sv
// ============================================================================
// Module   : uart_arb_rr
// Purpose  : Combinational 2-way round-robin picker with optional lock.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_arb_rr
  import uart_arb_pkg::*;
(
  input  logic [1:0] i_valid,      // bit 0 = CPU, bit 1 = debug
  input  logic       i_last_grant,
  input  logic       i_lock_en,
  input  logic       i_lock_id,
  output logic       o_winner
);

  always_comb begin
    o_winner = ~i_last_grant;
    if (i_lock_en) begin
      o_winner = i_lock_id;
    end else begin
      case (i_valid)
        2'b01:   o_winner = REQ_CPU;
        2'b10:   o_winner = REQ_DBG;
        default: o_winner = ~i_last_grant;  // tie or nobody: alternate
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
// ============================================================================
// Module   : uart_tx_arbiter
// Purpose  : Shares one UART transmitter between CPU and debug byte sources.
//            Optional line lock enabled by defining UART_ARB_LINE_LOCK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int START_TIMEOUT = 15,
  parameter int LOCK_TIMEOUT  = 1023
) (
  input  logic       clk,
  input  logic       reset_button,
  input  logic       cpu_valid,
  input  logic [7:0] cpu_data,
  output logic       cpu_ready,
  input  logic       dbg_valid,
  input  logic [7:0] dbg_data,
  output logic       dbg_ready,
  output logic       uart_transmit,
  output logic [7:0] uart_tx_byte,
  input  logic       uart_busy,
  output logic       grant_id,
  output logic       arb_busy,
  output logic       start_err
);

  localparam int SCW = (START_TIMEOUT > 0) ? $clog2(START_TIMEOUT + 1) : 1;

  arb_state_e       r_state;
  arb_state_e       w_state_next;
  logic [SCW-1:0]   r_start_cnt;
  logic [SCW-1:0]   w_start_cnt_inc;
  logic [7:0]       r_tx_byte;
  logic             r_grant;
  logic             r_start_err;
  logic             w_winner;
  logic             w_idle_free;
  logic             w_cpu_xfer;
  logic             w_dbg_xfer;
  logic             w_xfer;
  logic             w_xfer_id;
  logic [7:0]       w_xfer_data;
  logic             w_start_to;
  logic             w_lock_en;
  logic             w_lock_id;

  uart_arb_rr u_rr (
    .i_valid      ({dbg_valid, cpu_valid}),
    .i_last_grant (r_grant),
    .i_lock_en    (w_lock_en),
    .i_lock_id    (w_lock_id),
    .o_winner     (w_winner)
  );

  // Ready is withheld while a frame from before a reset is still on the line.
  assign w_idle_free = (r_state == ST_IDLE) & ~uart_busy & reset_button;
  assign cpu_ready   = w_idle_free & (w_winner == REQ_CPU);
  assign dbg_ready   = w_idle_free & (w_winner == REQ_DBG);

  assign w_cpu_xfer  = cpu_valid & cpu_ready;
  assign w_dbg_xfer  = dbg_valid & dbg_ready;
  assign w_xfer      = w_cpu_xfer | w_dbg_xfer;
  assign w_xfer_id   = w_dbg_xfer ? REQ_DBG : REQ_CPU;
  assign w_xfer_data = w_dbg_xfer ? dbg_data : cpu_data;

  assign w_start_cnt_inc = (r_start_cnt == SCW'(START_TIMEOUT)) ? r_start_cnt
                                                                : r_start_cnt + SCW'(1);
  assign w_start_to = (r_state == ST_WAIT_START) & ~uart_busy &
                      (w_start_cnt_inc == SCW'(START_TIMEOUT));

  always_ff @(posedge clk or negedge reset_button) begin
    if (!reset_button) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:       if (w_xfer) w_state_next = ST_LAUNCH;
      ST_LAUNCH:     w_state_next = ST_WAIT_START;
      ST_WAIT_START: begin
        if (uart_busy)       w_state_next = ST_WAIT_DONE;
        else if (w_start_to) w_state_next = ST_IDLE;
      end
      ST_WAIT_DONE:  if (!uart_busy) w_state_next = ST_IDLE;
      default:       w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    uart_transmit = (r_state == ST_LAUNCH);
    arb_busy      = (r_state != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset_button) begin
    if (!reset_button) begin
      r_tx_byte   <= 8'h00;
      r_grant     <= REQ_DBG;  // makes the CPU win the first tie
      r_start_cnt <= '0;
      r_start_err <= 1'b0;
    end else begin
      r_start_err <= w_start_to;
      if (w_xfer) begin
        r_tx_byte <= w_xfer_data;
        r_grant   <= w_xfer_id;
      end
      if (r_state == ST_LAUNCH) begin
        r_start_cnt <= '0;
      end else if ((r_state == ST_WAIT_START) && !uart_busy) begin
        r_start_cnt <= w_start_cnt_inc;
      end
    end
  end

  assign uart_tx_byte = r_tx_byte;
  assign grant_id     = r_grant;
  assign start_err    = r_start_err;

`ifdef UART_ARB_LINE_LOCK_EN
  localparam int LCW = (LOCK_TIMEOUT > 0) ? $clog2(LOCK_TIMEOUT + 1) : 1;

  logic           r_lock_en;
  logic           r_lock_id;
  logic [LCW-1:0] r_lock_idle;
  logic [LCW-1:0] w_lock_idle_inc;
  logic           w_holder_valid;
  logic           w_lock_expire;

  assign w_holder_valid  = (r_lock_id == REQ_DBG) ? dbg_valid : cpu_valid;
  assign w_lock_idle_inc = (r_lock_idle == LCW'(LOCK_TIMEOUT)) ? r_lock_idle
                                                               : r_lock_idle + LCW'(1);
  assign w_lock_expire   = r_lock_en & (r_state == ST_IDLE) & ~w_holder_valid &
                           (w_lock_idle_inc == LCW'(LOCK_TIMEOUT));

  // Lock holds until the holder ends its line, goes quiet, or its byte is lost.
  always_ff @(posedge clk or negedge reset_button) begin
    if (!reset_button) begin
      r_lock_en   <= 1'b0;
      r_lock_id   <= REQ_CPU;
      r_lock_idle <= '0;
    end else if (w_start_to) begin
      r_lock_en   <= 1'b0;
      r_lock_idle <= '0;
    end else if (w_xfer) begin
      r_lock_en   <= (w_xfer_data != ASCII_LF);
      r_lock_id   <= w_xfer_id;
      r_lock_idle <= '0;
    end else if (r_lock_en && (r_state == ST_IDLE)) begin
      if (w_holder_valid) begin
        r_lock_idle <= '0;
      end else if (w_lock_expire) begin
        r_lock_en   <= 1'b0;
        r_lock_idle <= '0;
      end else begin
        r_lock_idle <= w_lock_idle_inc;
      end
    end
  end

  assign w_lock_en = r_lock_en;
  assign w_lock_id = r_lock_id;
`else
  assign w_lock_en = 1'b0;
  assign w_lock_id = REQ_CPU;
`endif

endmodule

`default_nettype wire

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single UART transmitter between two byte sources: the CPU core's output port and the debug/monitor path. Each requester presents bytes over a valid/ready handshake. The arbiter picks a winner round-robin and launches the byte into the uart with a one-cycle `transmit` pulse. It then holds off further launches until the uart's `is_transmitting` flag has risen and fallen again. It sits between `cpu` and `uart`, in place of the direct `transmit`/`tx_byte` wiring.

## Interface
- `START_TIMEOUT`, default 15: maximum number of cycles in WAIT_START waiting for `uart_busy` to rise.
- `LOCK_TIMEOUT`, default 1023: maximum number of idle cycles a line lock may be held (line-lock builds only).
- `clk`  in  1  system clock; every register updates on the rising edge.
- `reset_button`  in  1  asynchronous, active-low reset.
- `cpu_valid`  in  1  CPU has a byte pending.
- `cpu_data`  in  8  CPU byte; held stable while `cpu_valid`=1 and `cpu_ready`=0.
- `cpu_ready`  out  1  the CPU byte is accepted at this edge if `cpu_valid`=1.
- `dbg_valid`, `dbg_data[7:0]`, `dbg_ready`: same handshake for the debug requester.
- `uart_transmit`  out  1  launch pulse to `uart.transmit`.
- `uart_tx_byte`  out  8  byte to `uart.tx_byte`.
- `uart_busy`  in  1  driven from `uart.is_transmitting`.
- `grant_id`  out  1  requester whose byte was accepted last (0 = CPU, 1 = debug).
- `arb_busy`  out  1  high whenever the state is not IDLE.
- `start_err`  out  1  one-cycle pulse when WAIT_START times out.

## Operation
- States: IDLE, LAUNCH, WAIT_START, WAIT_DONE.
- **IDLE**
  - `x_ready` = (state==IDLE) & !`uart_busy` & (winner==x) & `reset_button`. It is combinational from registered state and the valid inputs.
  - Winner: if only one requester is valid, that one wins. If both are valid, the requester that is not `grant_id` wins.
  - A transfer occurs when valid & ready are both high at an edge. On that edge the data is latched into `uart_tx_byte`, `grant_id` is updated, and the state goes to LAUNCH.
- **LAUNCH**: `uart_transmit`=1 for exactly one cycle, then go to WAIT_START and clear the timeout counter.
- **WAIT_START**
  - If `uart_busy`=1, go to WAIT_DONE.
  - Otherwise increment the counter. When it reaches `START_TIMEOUT`, pulse `start_err` and go to IDLE. The byte is dropped and is not retried.
- **WAIT_DONE**: when `uart_busy`=0, go to IDLE.
- `uart_tx_byte` holds its value until the next transfer.
- Counters are unsigned, sized as clog2(parameter + 1), and saturate. They never wrap.

## Timing
- Reset values:
  - state IDLE;
  - `uart_transmit` 0, `uart_tx_byte` 8'h00, `start_err` 0;
  - `grant_id` 1, so the CPU wins the first tie;
  - `cpu_ready`/`dbg_ready` 0 while reset is asserted;
  - `arb_busy` 0;
  - lock cleared.
- Latency: transfer at edge N, `uart_transmit` high during cycle N+1, WAIT_START from N+2.
- Back-to-back: at least one IDLE cycle after `uart_busy` falls before the next transfer.
- If `uart_busy` is already high in IDLE (for example a byte still in flight across a reset), both readies stay low.
- Reset asserted mid-byte:
  - the state returns to IDLE at once and `uart_transmit` drops;
  - the uart finishes its current frame on its own;
  - after release, no transfer occurs until `uart_busy`=0.
- A requester that drops valid before ready is treated as withdrawn; there is no error.

## Configuration
- `UART_ARB_LINE_LOCK_EN` defined: a transfer from requester x with a byte other than 8'h0A sets the lock to x.
  - While locked, only x can be granted.
  - The lock clears when x transfers 8'h0A.
  - The lock also clears after `LOCK_TIMEOUT` consecutive IDLE cycles in which `x_valid`=0.
  - A `start_err` also clears the lock.
- Macro undefined: pure per-byte round-robin; no lock register and no lock counter.

## Structure
- Package `uart_arb_pkg`:
  - state enum;
  - `REQ_CPU`=1'b0, `REQ_DBG`=1'b1;
  - `ASCII_LF`=8'h0A.
- Sub-module `uart_arb_rr`: the combinational 2-way round-robin picker (inputs: valids, last grant, lock; output: winner). It is reused by the future rx demultiplexer.

## Test plan
- CPU sends 8'h48 alone with a uart model (CLOCK_DIVIDE=1) -> `uart_transmit` pulses at N+1 with `uart_tx_byte`=8'h48; `grant_id`=0; `arb_busy` low after `uart_busy` falls.
- Both requesters valid from reset (CPU 8'h41, debug 8'h42) -> order 41, 42, 41, ...; each byte gets exactly one `transmit` pulse.
- `uart_busy` tied to 0 -> `start_err` pulses once 15 cycles after WAIT_START entry; the state returns to IDLE and the next byte is accepted.
- Reset asserted during WAIT_DONE while `uart_busy`=1 -> outputs take reset values; no ready until `uart_busy` falls.
- With `UART_ARB_LINE_LOCK_EN`: debug sends "OK\n" while the CPU is continuously valid -> 4F, 4B, 0A are sent before any CPU byte.
- With `UART_ARB_LINE_LOCK_EN`: debug sends "O" then goes silent -> the CPU is granted after 1023 IDLE cycles.
